cpu_run_monitor: RTL and testbench

CPU_RUN_MONITOR -- requirements
Module: cpu_run_monitor

---
 rtl/cpu_mon_pkg.sv | 21 ++
 rtl/cpu_halt_detect.sv | 42 ++++
 rtl/cpu_run_monitor.sv | 189 ++++++++++++++++++
 tb/tb_cpu_run_monitor.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mon_pkg.sv
// cpu_mon_pkg: shared state encoding, widths and helpers for the CPU run monitor.
package cpu_mon_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int PC_W       = 32;
    localparam int CNT_W      = 32;
    localparam int WCNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } mon_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cpu_halt_detect.sv
// cpu_halt_detect: flags a halted CPU once the PC has matched its previous-cycle
// value for HALT_REPEAT consecutive enabled cycles. halted is combinational so
// the run controller reacts in the same cycle the repeat count completes.
module cpu_halt_detect
    import cpu_mon_pkg::*;
#(
    parameter int HALT_REPEAT = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [PC_W-1:0] pc,
    output logic            halted
);

    localparam int                RPT_W    = $clog2(HALT_REPEAT + 1);
    localparam logic [RPT_W-1:0]  RPT_LAST = RPT_W'(HALT_REPEAT - 1);

    logic [PC_W-1:0]  prev_pc_q;
    logic [RPT_W-1:0] rpt_q;
    logic             same_pc;

    assign same_pc = (pc == prev_pc_q);
    assign halted  = enable && same_pc && (rpt_q == RPT_LAST);

    // Track the previous PC and count consecutive unchanged cycles while enabled.
    always_ff @(posedge clk) begin
        // NOTE: state registers use <= so every flop samples pre-edge values, whatever the statement order.
        if (!reset) begin
            prev_pc_q <= '0;
            rpt_q     <= '0;
        end else begin
            prev_pc_q <= pc;
            if (!enable || !same_pc) begin
                rpt_q <= '0;
            end else if (!halted) begin
                rpt_q <= rpt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: arms on start, snoops register-file writes into shadow
// copies of the checked registers, stops on CPU halt or timeout, then compares
// one shadow per cycle against its expected value and reports the verdict.
// Optional feature: define CPU_MON_WRITE_COUNT_EN to build the write counter;
// otherwise write_count is tied to zero.
module cpu_run_monitor
    import cpu_mon_pkg::*;
#(
    parameter int NUM_CHECKS     = 4,
    parameter int TIMEOUT_CYCLES = 2000,
    parameter int HALT_REPEAT    = 3,
    parameter int DATA_W         = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [PC_W-1:0]                  pc,
    input  logic                             rf_we,
    input  logic [REG_ADDR_W-1:0]            rf_waddr,
    input  logic [DATA_W-1:0]                rf_wdata,
    input  logic [NUM_CHECKS*REG_ADDR_W-1:0] exp_addr,
    input  logic [NUM_CHECKS*DATA_W-1:0]     exp_data,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic                             timeout,
    output logic [NUM_CHECKS-1:0]            fail_mask,
    output logic [CNT_W-1:0]                 cycle_count,
    output logic [WCNT_W-1:0]                write_count
);

    localparam int               IDX_W        = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_CHECKS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mon_state_e            state_q, state_d;
    logic [IDX_W-1:0]      chk_idx_q;
    logic [REG_ADDR_W-1:0] exp_addr_q [NUM_CHECKS];
    logic [DATA_W-1:0]     exp_data_q [NUM_CHECKS];
    logic [DATA_W-1:0]     shadow_q   [NUM_CHECKS];
    logic [NUM_CHECKS-1:0] fail_mask_q;
    logic [CNT_W-1:0]      cycle_count_q;
    logic                  timeout_q;

    logic in_run;
    logic halted;
    logic capture;
    logic timeout_hit;
    logic rf_write_ok;

    assign in_run      = (state_q == RUN);
    // Register 0 is hard-wired zero in the CPU, so writes to it are never tracked.
    assign rf_write_ok = in_run && rf_we && (rf_waddr != '0);

    cpu_halt_detect #(
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt_detect (
        .clk    (clk),
        .reset  (reset),
        .enable (in_run),
        .pc     (pc),
        .halted (halted)
    );

    // Next-state and status decode; halt takes priority over timeout.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves one unassigned (no latch).
        state_d     = state_q;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        busy        = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (halted) begin
                    state_d = CHECK;
                end else if (cycle_count_q >= TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                busy = 1'b1;
                if (chk_idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        done = (state_q == DONE);
        pass = done && (fail_mask_q == '0) && !timeout_q;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the check list when a run is armed.
    always_ff @(posedge clk) begin
        // NOTE: no reset here: every start reloads these before CHECK reads them, so their reset value is never observed.
        if (capture) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                exp_addr_q[i] <= exp_addr[i*REG_ADDR_W +: REG_ADDR_W];
                exp_data_q[i] <= exp_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Shadow every checked register; one write may hit several checks.
    always_ff @(posedge clk) begin
        if (!reset || capture) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (rf_write_ok) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                if (rf_waddr == exp_addr_q[i]) begin
                    shadow_q[i] <= rf_wdata;
                end
            end
        end
    end

    // Run cycle counter, timeout flag and the per-cycle comparison walk.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fail_mask_q   <= '0;
            cycle_count_q <= '0;
            timeout_q     <= 1'b0;
            chk_idx_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (capture) begin
                        fail_mask_q   <= '0;
                        cycle_count_q <= '0;
                        timeout_q     <= 1'b0;
                        chk_idx_q     <= '0;
                    end
                end
                RUN: begin
                    cycle_count_q <= sat_inc_cnt(cycle_count_q);
                    chk_idx_q     <= '0;
                    if (timeout_hit) begin
                        timeout_q <= 1'b1;
                    end
                end
                CHECK: begin
                    fail_mask_q[chk_idx_q] <= (shadow_q[chk_idx_q] != exp_data_q[chk_idx_q]);
                    chk_idx_q              <= chk_idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CPU_MON_WRITE_COUNT_EN
    logic [WCNT_W-1:0] write_count_q;

    // Count tracked register writes during a run, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!reset || capture) begin
            write_count_q <= '0;
        end else if (rf_write_ok && !(&write_count_q)) begin
            write_count_q <= write_count_q + 1'b1;
        end
    end

    assign write_count = write_count_q;
`else
    assign write_count = '0;
`endif

    assign fail_mask   = fail_mask_q;
    assign cycle_count = cycle_count_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb_cpu_run_monitor: directed runs of the CPU run monitor. Each run's expected
// verdict is queued when its stimulus starts and compared when done rises.
// Honours CPU_MON_WRITE_COUNT_EN when computing expected write counts.
module tb_cpu_run_monitor;

    localparam int NC = 4;
    localparam int TO = 50;
    localparam int HR = 3;
    localparam int DW = 32;
    localparam int WAIT_LIMIT = 200;

`ifdef CPU_MON_WRITE_COUNT_EN
    localparam bit WC_EN = 1'b1;
`else
    localparam bit WC_EN = 1'b0;
`endif

    typedef struct {
        string          tag;
        logic           pass;
        logic           timeout;
        logic [NC-1:0]  fail_mask;
        logic [31:0]    cycles;
        logic [15:0]    writes;
        int             latency;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      pc;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [DW-1:0]    rf_wdata;
    logic [NC*5-1:0]  exp_addr;
    logic [NC*DW-1:0] exp_data;
    logic             busy, done, pass, timeout;
    logic [NC-1:0]    fail_mask;
    logic [31:0]      cycle_count;
    logic [15:0]      write_count;

    cpu_run_monitor #(
        .NUM_CHECKS     (NC),
        .TIMEOUT_CYCLES (TO),
        .HALT_REPEAT    (HR),
        .DATA_W         (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pc          (pc),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .exp_addr    (exp_addr),
        .exp_data    (exp_data),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .fail_mask   (fail_mask),
        .cycle_count (cycle_count),
        .write_count (write_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] wc_exp(input int n);
        return WC_EN ? 16'(n) : 16'd0;
    endfunction

    function automatic exp_t mk(input string tag, input logic p, input logic t,
                                input logic [NC-1:0] fm, input logic [31:0] cc,
                                input logic [15:0] wc, input int lat);
        exp_t e;
        e.tag = tag; e.pass = p; e.timeout = t; e.fail_mask = fm;
        e.cycles = cc; e.writes = wc; e.latency = lat;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] p, input logic st);
        rf_we = we; rf_waddr = a; rf_wdata = d; pc = p; start = st;
        tick();
        rf_we = 1'b0; start = 1'b0;
    endtask

    task automatic start_run(input logic [NC*5-1:0] a, input logic [NC*DW-1:0] d,
                             input logic [31:0] p);
        exp_addr = a;
        exp_data = d;
        drive(1'b0, 5'd0, 32'd0, p, 1'b1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_done"},        32'(done),        32'd0);
        check({tag, "_pass"},        32'(pass),        32'd0);
        check({tag, "_timeout"},     32'(timeout),     32'd0);
        check({tag, "_fail_mask"},   32'(fail_mask),   32'd0);
        check({tag, "_cycle_count"}, cycle_count,      32'd0);
        check({tag, "_write_count"}, 32'(write_count), 32'd0);
    endtask

    // Wait (bounded) for done, optionally stepping pc by 4 each cycle, then
    // pop the queued expectation for this run and compare every result.
    task automatic finish_run(input bit inc_pc);
        exp_t e;
        int   n;
        n = 0;
        while (done !== 1'b1 && n < WAIT_LIMIT) begin
            if (inc_pc) pc = pc + 32'd4;
            tick();
            n++;
        end
        e = sb_q.pop_front();
        check({e.tag, "_latency"},     32'(n),           32'(e.latency));
        check({e.tag, "_done"},        32'(done),        32'd1);
        check({e.tag, "_busy"},        32'(busy),        32'd0);
        check({e.tag, "_pass"},        32'(pass),        32'(e.pass));
        check({e.tag, "_timeout"},     32'(timeout),     32'(e.timeout));
        check({e.tag, "_fail_mask"},   32'(fail_mask),   32'(e.fail_mask));
        check({e.tag, "_cycle_count"}, cycle_count,      e.cycles);
        check({e.tag, "_write_count"}, 32'(write_count), 32'(e.writes));
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; pc = '0; rf_we = 1'b0; rf_waddr = '0;
        rf_wdata = '0; exp_addr = '0; exp_data = '0;
        tick();
        tick();
        check_idle("por");
        reset = 1'b1;
        tick();
        check_idle("idle");

        // Two writes, one of them matching two checks; start mid-run ignored.
        sb_q.push_back(mk("basic", 1'b1, 1'b0, 4'b0000, 32'd6, wc_exp(2), 4));
        start_run({5'd0, 5'd4, 5'd5, 5'd4}, {32'd0, 32'd12, 32'd120, 32'd12}, 32'h10);
        drive(1'b1, 5'd4, 32'd12, 32'h14, 1'b0);
        check("basic_busy_run", 32'(busy), 32'd1);
        drive(1'b1, 5'd5, 32'd120, 32'h18, 1'b1);
        repeat (4) drive(1'b0, 5'd0, 32'd0, 32'h40, 1'b0);
        finish_run(1'b0);

        // Wrong value for r9; r5 not rewritten so its stale shadow must be cleared.
        sb_q.push_back(mk("mismatch", 1'b0, 1'b0, 4'b0011, 32'd5, wc_exp(1), 4));
        start_run({5'd0, 5'd0, 5'd5, 5'd9}, {32'd0, 32'd0, 32'd120, 32'd365}, 32'h100);
        drive(1'b1, 5'd9, 32'd364, 32'h104, 1'b0);
        repeat (4) drive(1'b0, 5'd0, 32'd0, 32'h200, 1'b0);
        finish_run(1'b0);

        // Writes to r0 are neither stored nor counted.
        sb_q.push_back(mk("r0_write", 1'b1, 1'b0, 4'b0000, 32'd4, 16'd0, 4));
        start_run('0, '0, 32'h2FC);
        drive(1'b1, 5'd0, 32'd7, 32'h300, 1'b0);
        repeat (3) drive(1'b0, 5'd0, 32'd0, 32'h300, 1'b0);
        finish_run(1'b0);

        // PC never repeats: timeout after TO run cycles, done TO+NC edges after the start edge.
        sb_q.push_back(mk("timeout", 1'b0, 1'b1, 4'b0000, 32'(TO), 16'd0, TO + NC));
        start_run('0, '0, 32'h1000);
        finish_run(1'b1);

        // Halt completes on the very cycle the timeout would fire: halt wins.
        sb_q.push_back(mk("halt_vs_timeout", 1'b1, 1'b0, 4'b0000, 32'(TO), 16'd0, 4));
        start_run('0, '0, 32'h0);
        for (int j = 1; j <= TO; j++) begin
            drive(1'b0, 5'd0, 32'd0, (j <= TO - HR) ? 32'(4 * j) : 32'(4 * (TO - HR)), 1'b0);
        end
        finish_run(1'b0);

        // Reset mid-run after ten writes, then a normal run.
        start_run({5'd4, 5'd3, 5'd2, 5'd1}, {32'd4, 32'd3, 32'd2, 32'd1}, 32'h600);
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 5'(k), 32'(k), 32'h600 + 32'(4 * k), 1'b0);
        end
        check("pre_reset_cycle_count", cycle_count, 32'd10);
        check("pre_reset_write_count", 32'(write_count), 32'(wc_exp(10)));
        reset = 1'b0;
        tick();
        check_idle("mid_run_reset");
        reset = 1'b1;
        sb_q.push_back(mk("after_reset", 1'b1, 1'b0, 4'b0000, 32'd7, wc_exp(4), 4));
        start_run({5'd4, 5'd3, 5'd2, 5'd1}, {32'd4, 32'd3, 32'd2, 32'd1}, 32'h700);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 5'(k), 32'(k), 32'h700 + 32'(4 * k), 1'b0);
        end
        repeat (3) drive(1'b0, 5'd0, 32'd0, 32'h710, 1'b0);
        finish_run(1'b0);

        // Write lands on the halt cycle; start during CHECK is ignored; DONE holds.
        sb_q.push_back(mk("late_write", 1'b1, 1'b0, 4'b0000, 32'd4, wc_exp(1), 3));
        start_run({5'd0, 5'd0, 5'd0, 5'd2}, {32'd0, 32'd0, 32'd0, 32'd58}, 32'h500);
        repeat (3) drive(1'b0, 5'd0, 32'd0, 32'h504, 1'b0);
        drive(1'b1, 5'd2, 32'd58, 32'h504, 1'b0);
        check("late_write_busy_check", 32'(busy), 32'd1);
        drive(1'b0, 5'd0, 32'd0, 32'h504, 1'b1);
        finish_run(1'b0);
        repeat (3) tick();
        check("hold_done",        32'(done), 32'd1);
        check("hold_pass",        32'(pass), 32'd1);
        check("hold_cycle_count", cycle_count, 32'd4);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
